midi_msg_decoder: RTL and testbench
===================================

// Module: midi_msg_decoder
// PURPOSE
//  Consumes the received-byte stream of the MIDI receiver (byteready/midibyte) and assembles
//  complete channel-voice messages: note on/off, control change, program change, pitch bend.
//  Emits one-cycle event strobes with held payload registers to the voice allocator and
//  controller maps. Handles running status and interleaved real-time bytes.
//  Fully synchronous to CLOCK_25; byteready arrives from the slow MIDI bit-clock domain.
// PARAMETERS
//  OMNI     1  1: accept all 16 channels; 0: accept only channel MIDI_CH
//  MIDI_CH  0  4-bit channel number used when OMNI=0
// PORTS
//  CLOCK_25     in   1   system clock, 25 MHz
//  reset_reg_N  in   1   asynchronous active-low reset
//  byteready    in   1   level pulse, >=2 CLOCK_25 cycles wide; high = midibyte valid
//  midibyte     in   8   received byte; stable while byteready high
//  note_on      out  1   1-cycle strobe: note on (velocity != 0)
//  note_off     out  1   1-cycle strobe: note off (8n, or 9n with velocity 0)
//  note_num     out  7   key number of last note event
//  velocity     out  7   velocity of last note event (0 for 9n-vel-0)
//  cc_valid     out  1   1-cycle strobe: control change
//  cc_num       out  7   controller number
//  cc_val       out  7   controller value
//  prog_valid   out  1   1-cycle strobe: program change
//  prog_num     out  7   program number
//  pb_valid     out  1   1-cycle strobe: pitch bend
//  pb_val       out  14  {MSB,LSB} bend value, 8192 = centre
//  msg_chan     out  4   channel of the most recent emitted event
// BEHAVIOUR
//  Reset: all strobes 0, payloads 0, pb_val=14'd8192, msg_chan 0, FSM IDLE, running status invalid.
//  Input sync: byteready -> 2-flop sync -> edge reg; byte_stb = sync2 & ~sync3 (one per byte).
//  midibyte is captured on byte_stb. Latency: strobe is registered 1 cycle after byte_stb
//   (3 CLOCK_25 edges after the first edge sampling byteready high).
//  Byte classes on byte_stb:
//   F8..FF real-time: ignored entirely; state, running status and partial message untouched.
//   F0..F7 system common/SysEx: running status invalidated, FSM -> IDLE, following data discarded.
//   80..EF channel status: latch run_stat, FSM -> D1 (partial message dropped).
//   00..7F data: IDLE+invalid status -> discard; else handled by FSM.
//  FSM: IDLE, D1, D2.
//   D1 + data: 1-data msgs (Cn, Dn): Cn emits prog_valid; Dn consumed silently; stay D1.
//              2-data msgs (8n, 9n, An, Bn, En): store data1, -> D2.
//   D2 + data: emit event, -> D1 (running status: next data byte starts new message).
//              An (poly aftertouch) consumed silently.
//   IDLE + data with valid status: behaves as D1.
//  Channel filter (OMNI=0): status with chan != MIDI_CH still latched and bytes counted, but no
//   strobe and no payload/msg_chan update on completion.
//  Payload regs update in the same cycle their strobe asserts; held until next such event.
//  At most one strobe high per cycle; strobes never exceed 1 cycle.
//  pb_val = {data2[6:0], data1[6:0]}. Data bit 7 never leaks into payloads.
//  Reset mid-message: asynchronous; partial message lost, no strobe after release until a
//   fresh status byte is received.
// TESTING
//  1. 90 3C 64 -> note_on=1 one cycle, note_num=60, velocity=100, msg_chan=0.
//  2. Running status 91 40 7F 40 00 -> note_on (64,127,ch1) then note_off (64,0,ch1).
//  3. 90 3C F8 64 (clock inside msg) -> single note_on (60,100); no extra strobe.
//  4. E2 00 40, then E2 7F 7F -> pb_val=8192 then 16383, msg_chan=2; C5 07 -> prog_valid, prog_num=7.
//  5. OMNI=0, MIDI_CH=3: B0 07 64 -> no strobe; B3 07 64 -> cc_valid, cc_num=7, cc_val=100.
//  6. 90 3C, F0 7E 7F F7, 64 -> no strobe (status invalidated); reset_reg_N low after 90 3C -> all outputs reset values.

Source files
------------

// File: rtl/midi_msg_decoder.sv
// midi_msg_decoder: assembles MIDI channel-voice messages from the receiver byte
// stream and emits one-cycle event strobes with held payload registers.
// Running status and interleaved real-time bytes are handled transparently.
module midi_msg_decoder #(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] MIDI_CH = 4'd0
) (
  input  logic        CLOCK_25,
  input  logic        reset_reg_N,
  input  logic        byteready,
  input  logic [7:0]  midibyte,
  output logic        note_on,
  output logic        note_off,
  output logic [6:0]  note_num,
  output logic [6:0]  velocity,
  output logic        cc_valid,
  output logic [6:0]  cc_num,
  output logic [6:0]  cc_val,
  output logic        prog_valid,
  output logic [6:0]  prog_num,
  output logic        pb_valid,
  output logic [13:0] pb_val,
  output logic [3:0]  msg_chan
);

  typedef enum logic [1:0] {IDLE, D1, D2} state_t;

  state_t      state, state_nx;
  logic        sync_p0, sync_p1, sync_p2;
  logic        byte_stb;
  logic        vld_p3;
  logic [7:0]  byte_p3;
  logic [7:0]  run_stat, run_stat_nx;
  logic        stat_ok, stat_ok_nx;
  logic [6:0]  data1;
  logic        data1_ld;
  logic        chan_ok;
  logic        ev_on, ev_off, ev_cc, ev_prog, ev_pb;

  // --- stage p0..p2: byteready crosses in from the MIDI bit-clock domain
  // Two-flop synchroniser plus an edge register to find the rising edge
  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= byteready;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign byte_stb = sync_p1 & ~sync_p2;

  // --- stage p3: one captured byte per byteready pulse
  // Byte-valid flag travels with the captured byte
  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) vld_p3 <= 1'b0;
    else              vld_p3 <= byte_stb;
  end

  // Data-only registers: captured byte and first data byte of a 2-byte message
  always_ff @(posedge CLOCK_25) begin
    if (byte_stb)          byte_p3 <= midibyte;
    if (vld_p3 && data1_ld) data1   <= byte_p3[6:0];
  end

  assign chan_ok = OMNI | (run_stat[3:0] == MIDI_CH);

  // Parser state register: FSM state and running status
  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state    <= IDLE;
      run_stat <= 8'h00;
      stat_ok  <= 1'b0;
    end else begin
      state    <= state_nx;
      run_stat <= run_stat_nx;
      stat_ok  <= stat_ok_nx;
    end
  end

  // Byte classification, next state and event decode for the captured byte
  always_comb begin
    state_nx    = state;
    run_stat_nx = run_stat;
    stat_ok_nx  = stat_ok;
    data1_ld    = 1'b0;
    ev_on       = 1'b0;
    ev_off      = 1'b0;
    ev_cc       = 1'b0;
    ev_prog     = 1'b0;
    ev_pb       = 1'b0;
    if (vld_p3) begin
      if (byte_p3[7:3] == 5'b11111) begin
        // real-time byte: leaves the message in progress untouched
      end else if (byte_p3[7:4] == 4'hF) begin
        stat_ok_nx = 1'b0;
        state_nx   = IDLE;
      end else if (byte_p3[7]) begin
        run_stat_nx = byte_p3;
        stat_ok_nx  = 1'b1;
        state_nx    = D1;
      end else if (stat_ok) begin
        state_nx = D1;
        if (state == D2) begin
          unique case (run_stat[7:4])
            4'h8:    ev_off = chan_ok;
            4'h9: begin
              ev_off = chan_ok & (byte_p3[6:0] == 7'd0);
              ev_on  = chan_ok & (byte_p3[6:0] != 7'd0);
            end
            4'hB:    ev_cc  = chan_ok;
            4'hE:    ev_pb  = chan_ok;
            default: ;
          endcase
        end else begin
          unique case (run_stat[7:4])
            4'hC:    ev_prog = chan_ok;
            4'hD:    ;
            default: begin
              data1_ld = 1'b1;
              state_nx = D2;
            end
          endcase
        end
      end
    end
  end

  // --- stage p4: registered strobes and held payloads
  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      note_on    <= 1'b0;
      note_off   <= 1'b0;
      cc_valid   <= 1'b0;
      prog_valid <= 1'b0;
      pb_valid   <= 1'b0;
      note_num   <= 7'd0;
      velocity   <= 7'd0;
      cc_num     <= 7'd0;
      cc_val     <= 7'd0;
      prog_num   <= 7'd0;
      pb_val     <= 14'd8192;
      msg_chan   <= 4'd0;
    end else begin
      note_on    <= ev_on;
      note_off   <= ev_off;
      cc_valid   <= ev_cc;
      prog_valid <= ev_prog;
      pb_valid   <= ev_pb;
      if (ev_on || ev_off) begin
        note_num <= data1;
        velocity <= byte_p3[6:0];
      end
      if (ev_cc) begin
        cc_num <= data1;
        cc_val <= byte_p3[6:0];
      end
      if (ev_prog) prog_num <= byte_p3[6:0];
      if (ev_pb)   pb_val   <= {byte_p3[6:0], data1};
      if (ev_on || ev_off || ev_cc || ev_prog || ev_pb) msg_chan <= run_stat[3:0];
    end
  end

endmodule

// File: tb/tb_midi_msg_decoder.sv
// tb_midi_msg_decoder: scoreboard bench for two decoder instances (omni and
// channel-3 only). A message-level model turns each sent byte into expected
// events; per-instance monitors pop and compare whenever a strobe appears.
module tb_midi_msg_decoder;

  typedef struct packed {
    logic [6:0]  note;
    logic [6:0]  vel;
    logic [6:0]  ccn;
    logic [6:0]  ccv;
    logic [6:0]  prog;
    logic [13:0] pb;
    logic [3:0]  ch;
  } held_t;

  // kind: 0 note_on, 1 note_off, 2 cc, 3 prog, 4 pitch bend
  typedef struct {
    int kind;
    int a;
    int b;
    int ch;
  } ev_t;

  localparam held_t RST_HELD = '{note: 7'd0, vel: 7'd0, ccn: 7'd0, ccv: 7'd0,
                                 prog: 7'd0, pb: 14'd8192, ch: 4'd0};

  logic        CLOCK_25 = 1'b0;
  logic        reset_reg_N = 1'b0;
  logic        byteready = 1'b0;
  logic [7:0]  midibyte = 8'h00;

  logic        on0, off0, ccv0, prv0, pbv0;
  logic [6:0]  nn0, vel0, ccn0, ccval0, prn0;
  logic [13:0] pb0;
  logic [3:0]  ch0;
  logic        on1, off1, ccv1, prv1, pbv1;
  logic [6:0]  nn1, vel1, ccn1, ccval1, prn1;
  logic [13:0] pb1;
  logic [3:0]  ch1;

  int checks = 0;
  int failures = 0;

  ev_t   q0[$];
  ev_t   q1[$];
  held_t exp_held [2];

  int    rs = -1;
  int    pend[$];

  always #20 CLOCK_25 = ~CLOCK_25;

  midi_msg_decoder #(.OMNI(1'b1), .MIDI_CH(4'd0)) dut0 (
    .CLOCK_25(CLOCK_25), .reset_reg_N(reset_reg_N), .byteready(byteready), .midibyte(midibyte),
    .note_on(on0), .note_off(off0), .note_num(nn0), .velocity(vel0),
    .cc_valid(ccv0), .cc_num(ccn0), .cc_val(ccval0),
    .prog_valid(prv0), .prog_num(prn0), .pb_valid(pbv0), .pb_val(pb0), .msg_chan(ch0)
  );

  midi_msg_decoder #(.OMNI(1'b0), .MIDI_CH(4'd3)) dut1 (
    .CLOCK_25(CLOCK_25), .reset_reg_N(reset_reg_N), .byteready(byteready), .midibyte(midibyte),
    .note_on(on1), .note_off(off1), .note_num(nn1), .velocity(vel1),
    .cc_valid(ccv1), .cc_num(ccn1), .cc_val(ccval1),
    .prog_valid(prv1), .prog_num(prn1), .pb_valid(pbv1), .pb_val(pb1), .msg_chan(ch1)
  );

  // Message-level reference: running status byte plus list of collected data bytes
  function void model_byte(input int b);
    int  hi;
    int  need;
    bit  emit;
    ev_t e;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      rs = -1;
      pend.delete();
      return;
    end
    if (b >= 'h80) begin
      rs = b;
      pend.delete();
      return;
    end
    if (rs < 0) return;
    pend.push_back(b);
    hi   = rs / 16;
    need = (hi == 'hC || hi == 'hD) ? 1 : 2;
    if (pend.size() < need) return;
    emit = 1'b1;
    e.ch = rs % 16;
    e.a  = pend[0];
    e.b  = (need == 2) ? pend[1] : 0;
    case (hi)
      'h8: e.kind = 1;
      'h9: e.kind = (pend[1] == 0) ? 1 : 0;
      'hB: e.kind = 2;
      'hC: e.kind = 3;
      'hE: begin
        e.kind = 4;
        e.a = pend[1] * 128 + pend[0];
      end
      default: emit = 1'b0;
    endcase
    pend.delete();
    if (emit) begin
      q0.push_back(e);
      if (e.ch == 3) q1.push_back(e);
    end
  endfunction

  function held_t apply_ev(input held_t h, input ev_t e);
    held_t r;
    r = h;
    case (e.kind)
      0, 1: begin r.note = 7'(e.a); r.vel = 7'(e.b); end
      2:    begin r.ccn = 7'(e.a); r.ccv = 7'(e.b); end
      3:    r.prog = 7'(e.a);
      default: r.pb = 14'(e.a);
    endcase
    r.ch = 4'(e.ch);
    return r;
  endfunction

  task automatic check_dut(input int idx, input logic [4:0] stb, input held_t h);
    ev_t   e;
    bit    empty;
    held_t want;
    if (stb == 5'd0) return;
    checks++;
    if ($countones(stb) != 1) begin
      failures++;
      $display("FAIL onehot_strobe dut%0d: got strobes=%b, required exactly one", idx, stb);
    end
    empty = (idx == 0) ? (q0.size() == 0) : (q1.size() == 0);
    checks++;
    if (empty) begin
      failures++;
      $display("FAIL unexpected_event dut%0d: got strobes=%b held=%h, required no event", idx, stb, h);
      return;
    end
    e = (idx == 0) ? q0.pop_front() : q1.pop_front();
    if (stb != 5'(1 << e.kind)) begin
      failures++;
      $display("FAIL event_kind dut%0d: got strobes=%b, required %b", idx, stb, 5'(1 << e.kind));
    end
    want = apply_ev(exp_held[idx], e);
    exp_held[idx] = want;
    checks++;
    if (h !== want) begin
      failures++;
      $display("FAIL payload dut%0d: got %h, required %h", idx, h, want);
    end
  endtask

  // Monitors: sample both instances away from the active edge
  always @(negedge CLOCK_25) begin
    if (reset_reg_N) begin
      check_dut(0, {pbv0, prv0, ccv0, off0, on0},
                '{note: nn0, vel: vel0, ccn: ccn0, ccv: ccval0, prog: prn0, pb: pb0, ch: ch0});
      check_dut(1, {pbv1, prv1, ccv1, off1, on1},
                '{note: nn1, vel: vel1, ccn: ccn1, ccv: ccval1, prog: prn1, pb: pb1, ch: ch1});
    end
  end

  task automatic check_reset_state(input string tag);
    held_t h0, h1;
    h0 = '{note: nn0, vel: vel0, ccn: ccn0, ccv: ccval0, prog: prn0, pb: pb0, ch: ch0};
    h1 = '{note: nn1, vel: vel1, ccn: ccn1, ccv: ccval1, prog: prn1, pb: pb1, ch: ch1};
    checks++;
    if ({pbv0, prv0, ccv0, off0, on0, pbv1, prv1, ccv1, off1, on1} !== 10'd0) begin
      failures++;
      $display("FAIL %s_strobes: got %b, required 0", tag,
               {pbv0, prv0, ccv0, off0, on0, pbv1, prv1, ccv1, off1, on1});
    end
    checks++;
    if (h0 !== RST_HELD || h1 !== RST_HELD) begin
      failures++;
      $display("FAIL %s_payload: got %h / %h, required %h", tag, h0, h1, RST_HELD);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(int'(b));
    @(posedge CLOCK_25);
    #2 midibyte = b;
    byteready = 1'b1;
    repeat (3) @(posedge CLOCK_25);
    #2 byteready = 1'b0;
    repeat (4) @(posedge CLOCK_25);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic do_reset(input string tag);
    @(posedge CLOCK_25);
    #7 reset_reg_N = 1'b0;
    #1 check_reset_state(tag);
    rs = -1;
    pend.delete();
    exp_held[0] = RST_HELD;
    exp_held[1] = RST_HELD;
    repeat (3) @(posedge CLOCK_25);
    #5 reset_reg_N = 1'b1;
    repeat (2) @(posedge CLOCK_25);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int         r;
    exp_held[0] = RST_HELD;
    exp_held[1] = RST_HELD;
    repeat (3) @(posedge CLOCK_25);
    #1 check_reset_state("initial_reset");
    #5 reset_reg_N = 1'b1;
    repeat (2) @(posedge CLOCK_25);

    send_seq('{8'h90, 8'h3C, 8'h64});
    send_seq('{8'h91, 8'h40, 8'h7F, 8'h40, 8'h00});
    send_seq('{8'h90, 8'h3C, 8'hF8, 8'h64});
    send_seq('{8'hE2, 8'h00, 8'h40, 8'hE2, 8'h7F, 8'h7F});
    send_seq('{8'hC5, 8'h07, 8'h0B});
    send_seq('{8'hB0, 8'h07, 8'h64, 8'hB3, 8'h07, 8'h64, 8'h0A, 8'h7F});
    send_seq('{8'h83, 8'h21, 8'h33, 8'hE3, 8'h01, 8'h02, 8'hC3, 8'h55});
    send_seq('{8'hA3, 8'h10, 8'h20, 8'hD3, 8'h30, 8'h93, 8'h11, 8'h22});
    send_seq('{8'h90, 8'h3C, 8'hF0, 8'h7E, 8'h7F, 8'hF7, 8'h64, 8'h12});
    send_seq('{8'h90, 8'h3C});
    do_reset("midmsg_reset");
    send_seq('{8'h64, 8'h3C, 8'h64});
    send_seq('{8'h93, 8'h45, 8'h50});

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)        b = 8'h00;
      else if (r < 60)  b = 8'($urandom_range(0, 127));
      else if (r < 80)  b = 8'({4'($urandom_range(8, 14)), 4'($urandom_range(0, 3))});
      else if (r < 92)  b = 8'($urandom_range(8'hF8, 8'hFF));
      else              b = 8'($urandom_range(8'hF0, 8'hF7));
      send_byte(b);
    end

    repeat (10) @(posedge CLOCK_25);
    #1;
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL missing_events dut0: got %0d unmatched, required 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL missing_events dut1: got %0d unmatched, required 0", q1.size());
    end
    do_reset("final_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
